// File: rtl/pc_pkg.sv
// pc_pkg: shared constants and types for the program-counter stage.
//   PC_WIDTH        default PC/data width
//   PC_RESET_VECTOR default address loaded by reset
//   PC_INC          sequential fetch increment in bytes
//   pc_sel_t        next-PC mux select, produced by the priority encoder
package pc_pkg;

    localparam int          PC_WIDTH        = 32;
    localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
    localparam int          PC_INC          = 4;

    typedef enum logic [1:0] {
        SEL_SEQ,
        SEL_BRANCH,
        SEL_JUMP,
        SEL_JR
    } pc_sel_t;

endpackage

// File: rtl/pc_next_unit_if.sv
// pc_next_unit_if: control and address bundle between the fetch controller
// and the PC stage.
//   master : fetch/decode side, drives control, observes PC outputs
//   slave  : pc_next_unit, consumes control, drives PC outputs
//   stall, branch_taken, branch_imm, jump, jump_target, jr, jr_addr  (master -> slave)
//   pc_out, pc_plus4, next_pc                                         (slave -> master)
interface pc_next_unit_if #(
    parameter int WIDTH = 32
);

    logic             stall;
    logic             branch_taken;
    logic [15:0]      branch_imm;
    logic             jump;
    logic [25:0]      jump_target;
    logic             jr;
    logic [WIDTH-1:0] jr_addr;
    logic [WIDTH-1:0] pc_out;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] next_pc;

    modport master (
        output stall, branch_taken, branch_imm, jump, jump_target, jr, jr_addr,
        input  pc_out, pc_plus4, next_pc
    );

    modport slave (
        input  stall, branch_taken, branch_imm, jump, jump_target, jr, jr_addr,
        output pc_out, pc_plus4, next_pc
    );

endinterface

// File: rtl/pc_adder.sv
// pc_adder: combinational WIDTH-bit adder, carry out discarded so results
// wrap modulo 2^WIDTH.
//   a_i, b_i : operands
//   sum_o    : (a_i + b_i) mod 2^WIDTH
module pc_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule

// File: rtl/pc_next_unit.sv
// pc_next_unit: program-counter register and next-PC selection for fetch.
//   clk  : rising-edge clock
//   rst  : synchronous active-low reset, PC <- RESET_VECTOR
//   bus  : pc_next_unit_if.slave
//          inputs  stall, branch_taken/branch_imm, jump/jump_target, jr/jr_addr
//          outputs pc_out (registered), pc_plus4, next_pc (combinational)
// Next-PC priority: jr > jump > branch > sequential. stall only blocks the
// register load; next_pc still shows the selected target.
module pc_next_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH        = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR),
    parameter int               INC          = PC_INC
) (
    input  logic           clk,
    input  logic           rst,
    pc_next_unit_if.slave  bus
);

    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] br_off;
    logic [WIDTH-1:0] br_tgt;
    logic [WIDTH-1:0] j_tgt;
    pc_sel_t          sel;

    // Sequential increment.
    pc_adder #(.WIDTH(WIDTH)) u_inc (
        .a_i   (pc_q),
        .b_i   (INC_W),
        .sum_o (pc_plus4)
    );

    // Word offset -> byte offset: sign-extend the immediate, then shift by 2.
    assign br_off = {{(WIDTH-18){bus.branch_imm[15]}}, bus.branch_imm, 2'b00};

    pc_adder #(.WIDTH(WIDTH)) u_br (
        .a_i   (pc_plus4),
        .b_i   (br_off),
        .sum_o (br_tgt)
    );

    // J-type keeps the region bits above bit 27 from PC+4; at WIDTH=28 there
    // are none and the target is just the shifted instr_index.
    generate
        if (WIDTH > 28) begin : g_jregion
            assign j_tgt = {pc_plus4[WIDTH-1:28], bus.jump_target, 2'b00};
        end else begin : g_jflat
            assign j_tgt = {bus.jump_target, 2'b00};
        end
    endgenerate

    always_comb begin
        sel = SEL_SEQ;
        if (bus.jr)                sel = SEL_JR;
        else if (bus.jump)         sel = SEL_JUMP;
        else if (bus.branch_taken) sel = SEL_BRANCH;
    end

    always_comb begin
        pc_d = pc_plus4;
        unique case (sel)
            SEL_JR:     pc_d = bus.jr_addr;
            SEL_JUMP:   pc_d = j_tgt;
            SEL_BRANCH: pc_d = br_tgt;
            default:    pc_d = pc_plus4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst)            pc_q <= RESET_VECTOR;
        else if (!bus.stall) pc_q <= pc_d;
    end

    assign bus.pc_out   = pc_q;
    assign bus.pc_plus4 = pc_plus4;
    assign bus.next_pc  = pc_d;

endmodule

// File: tb/tb_pc_next_unit.sv
module tb_pc_next_unit;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    pc_next_unit_if #(.WIDTH(32)) bus ();

    pc_next_unit #(
        .WIDTH        (32),
        .RESET_VECTOR (32'h0000_0000),
        .INC          (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural rules stated as plain arithmetic.
    function automatic logic [31:0] model_next(input logic [31:0] pc);
        logic [31:0] p4;
        p4 = pc + 32'd4;
        if (bus.jr)                return bus.jr_addr;
        if (bus.jump)              return (p4 & 32'hF000_0000) | (32'(bus.jump_target) * 32'd4);
        if (bus.branch_taken)      return p4 + 32'(int'($signed(bus.branch_imm)) * 4);
        return p4;
    endfunction

    logic [31:0] m_pc;
    bit          m_valid = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            m_pc    <= 32'h0000_0000;
            m_valid <= 1'b1;
        end else if (m_valid && !bus.stall) begin
            m_pc <= model_next(m_pc);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_pc_out",   bus.pc_out,   m_pc);
            chk("model_pc_plus4", bus.pc_plus4, m_pc + 32'd4);
            chk("model_next_pc",  bus.next_pc,  model_next(m_pc));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.stall        = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_imm   = 16'h0000;
        bus.jump         = 1'b0;
        bus.jump_target  = 26'h0;
        bus.jr           = 1'b0;
        bus.jr_addr      = 32'h0;
    endtask

    // Load an arbitrary PC through the jr path.
    task automatic load_pc(input logic [31:0] a);
        clr();
        bus.jr      = 1'b1;
        bus.jr_addr = a;
        tick();
        clr();
    endtask

    initial begin
        rst = 1'b0;
        clr();

        // Reset, then free-run.
        tick();
        chk("reset_pc_out",   bus.pc_out,   32'h0);
        chk("reset_pc_plus4", bus.pc_plus4, 32'h4);
        chk("reset_next_pc",  bus.next_pc,  32'h4);
        rst = 1'b1;
        tick(); chk("run_4",  bus.pc_out, 32'h4);
        tick(); chk("run_8",  bus.pc_out, 32'h8);
        tick(); chk("run_12", bus.pc_out, 32'hC);
        chk("run_12_plus4", bus.pc_plus4, 32'h10);

        // Mid-run reset, then a reset pulse entirely between edges.
        rst = 1'b0;
        tick(); chk("midrst_0", bus.pc_out, 32'h0);
        rst = 1'b1;
        tick(); chk("midrst_4", bus.pc_out, 32'h4);
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        chk("glitch_hold", bus.pc_out, 32'h4);
        tick(); chk("glitch_8", bus.pc_out, 32'h8);

        // Branches.
        load_pc(32'h100);
        chk("load_100", bus.pc_out, 32'h100);
        bus.branch_taken = 1'b1;
        bus.branch_imm   = 16'hFFFE;
        #1 chk("br_back_next", bus.next_pc, 32'h0FC);
        tick(); chk("br_back_pc", bus.pc_out, 32'h0FC);
        load_pc(32'h100);
        bus.branch_taken = 1'b1;
        bus.branch_imm   = 16'h0003;
        #1 chk("br_fwd_next", bus.next_pc, 32'h110);
        tick(); chk("br_fwd_pc", bus.pc_out, 32'h110);
        clr();

        // Jump, then jr over jump and branch together.
        load_pc(32'h1000_0000);
        bus.jump        = 1'b1;
        bus.jump_target = 26'h000_0040;
        tick(); chk("jump_pc", bus.pc_out, 32'h1000_0100);
        bus.jump         = 1'b1;
        bus.branch_taken = 1'b1;
        bus.branch_imm   = 16'h0010;
        bus.jr           = 1'b1;
        bus.jr_addr      = 32'hDEAD_BEE0;
        #1 chk("jr_prio_next", bus.next_pc, 32'hDEAD_BEE0);
        tick(); chk("jr_prio_pc", bus.pc_out, 32'hDEAD_BEE0);
        clr();
        // Jump over branch, with a region taken from PC+4.
        load_pc(32'hA000_0000);
        bus.jump         = 1'b1;
        bus.jump_target  = 26'h3FF_FFFF;
        bus.branch_taken = 1'b1;
        bus.branch_imm   = 16'h0001;
        tick(); chk("jump_prio_pc", bus.pc_out, 32'hAFFF_FFFC);
        clr();

        // Stall holds PC while next_pc still shows the selection.
        load_pc(32'h20);
        bus.stall = 1'b1;
        #1 chk("stall_next", bus.next_pc, 32'h24);
        for (int i = 0; i < 3; i++) begin
            tick(); chk("stall_hold", bus.pc_out, 32'h20);
        end
        bus.jump        = 1'b1;
        bus.jump_target = 26'h000_0100;
        #1 chk("stall_jump_next", bus.next_pc, 32'h0000_0400);
        tick(); chk("stall_jump_hold", bus.pc_out, 32'h20);
        rst = 1'b0;
        tick(); chk("stall_rst", bus.pc_out, 32'h0);
        rst = 1'b1;
        clr();
        tick(); chk("post_rst_4", bus.pc_out, 32'h4);

        // Wrap-around.
        load_pc(32'hFFFF_FFFC);
        chk("wrap_plus4", bus.pc_plus4, 32'h0);
        tick();
        chk("wrap_pc",       bus.pc_out,   32'h0);
        chk("wrap_pc_plus4", bus.pc_plus4, 32'h4);
        // Branch wrapping backwards past zero.
        bus.branch_taken = 1'b1;
        bus.branch_imm   = 16'h8000;
        tick(); chk("br_wrap", bus.pc_out, 32'hFFFE_0004);
        clr();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
